// File: rtl/wt_column_loader.sv
// wt_column_loader: turns a serial, column-major stream of weight words into
// one column write per RAM column. Columns are written in order for every
// layer, and each column is zero-padded to MAX_NEURONS entries.
// Optional feature macro: LOAD_CHECKSUM_EN adds a 16-bit running checksum
// output that sums the low half of every accepted word.
module wt_column_loader #(
  parameter int DATA_W      = 32,
  parameter int MAX_NEURONS = 8,
  parameter int MAX_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [$clog2(MAX_DEPTH+1)-1:0]       cfg_layers,
  input  logic [$clog2(MAX_NEURONS+1)-1:0]     cfg_cols,
  input  logic [$clog2(MAX_NEURONS+1)-1:0]     cfg_rows,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_W-1:0]                    in_data,
  output logic                                 ram_rw,
  output logic [31:0]                          ram_layer,
  output logic [31:0]                          ram_col,
  output logic [MAX_NEURONS*DATA_W-1:0]        ram_column,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 cfg_err
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [15:0]                          checksum
`endif
);

  localparam int LW = $clog2(MAX_DEPTH + 1);
  localparam int NW = $clog2(MAX_NEURONS + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    FINISH
  } state_t;

  state_t state, next_state;

  logic [LW-1:0]     layers_q, layer;
  logic [NW-1:0]     cols_q, rows_q, col, row;
  logic [DATA_W-1:0] col_buf [MAX_NEURONS];
  logic [MAX_NEURONS*DATA_W-1:0] next_column;

  logic accept, last_row, last_col, last_layer, cfg_ok;

  assign in_ready = (state == COLLECT);
  assign ram_rw   = (state == WRITE);
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);

  assign accept     = in_valid && in_ready;
  assign last_row   = (row == rows_q - NW'(1));
  assign last_col   = (col == cols_q - NW'(1));
  assign last_layer = (layer == layers_q - LW'(1));

  assign cfg_ok = (cfg_layers != '0) && (cfg_layers <= LW'(MAX_DEPTH)) &&
                  (cfg_cols   != '0) && (cfg_cols   <= NW'(MAX_NEURONS)) &&
                  (cfg_rows   != '0) && (cfg_rows   <= NW'(MAX_NEURONS));

  // Column image as it will look once the word on in_data lands at buf[row]
  always_comb begin
    next_column = '0;
    for (int i = 0; i < MAX_NEURONS; i++) begin
      next_column[i*DATA_W +: DATA_W] = (row == NW'(i)) ? in_data : col_buf[i];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; WRITE and FINISH each last exactly one cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && cfg_ok) next_state = COLLECT;
      COLLECT: if (accept && last_row) next_state = WRITE;
      WRITE:   next_state = (last_col && last_layer) ? FINISH : COLLECT;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: config latch, counters, column buffer and RAM-facing registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layers_q   <= '0;
      cols_q     <= '0;
      rows_q     <= '0;
      layer      <= '0;
      col        <= '0;
      row        <= '0;
      ram_layer  <= '0;
      ram_col    <= '0;
      ram_column <= '0;
      cfg_err    <= 1'b0;
      for (int i = 0; i < MAX_NEURONS; i++) col_buf[i] <= '0;
`ifdef LOAD_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              layers_q <= cfg_layers;
              cols_q   <= cfg_cols;
              rows_q   <= cfg_rows;
              layer    <= '0;
              col      <= '0;
              row      <= '0;
              for (int i = 0; i < MAX_NEURONS; i++) col_buf[i] <= '0;
`ifdef LOAD_CHECKSUM_EN
              checksum <= '0;
`endif
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            for (int i = 0; i < MAX_NEURONS; i++) begin
              if (row == NW'(i)) col_buf[i] <= in_data;
            end
            row <= row + NW'(1);
`ifdef LOAD_CHECKSUM_EN
            checksum <= checksum + in_data[15:0];
`endif
            if (last_row) begin
              ram_layer  <= 32'(layer);
              ram_col    <= 32'(col);
              ram_column <= next_column;
            end
          end
        end
        WRITE: begin
          row <= '0;
          for (int i = 0; i < MAX_NEURONS; i++) col_buf[i] <= '0;
          if (last_col) begin
            col <= '0;
            if (!last_layer) layer <= layer + LW'(1);
          end else begin
            col <= col + NW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
